// File: rtl/serial_pattern_tx_pkg.sv
// Shared definitions for the serial pattern transmitter and the detectors/benches that consume its stream.
package serial_pattern_tx_pkg;

  localparam int unsigned TX_WIDTH = 6;
  localparam int unsigned TX_LEN_W = 3;
  localparam int unsigned TX_REP_W = 4;

  // Encoding is fixed so detector FSMs and benches can decode it directly.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_pattern_tx_if.sv
// Word-in / bit-out bus between a stimulus source and the serial pattern transmitter.
interface serial_pattern_tx_if
  import serial_pattern_tx_pkg::*;
#(
  parameter int unsigned WIDTH = TX_WIDTH,
  parameter int unsigned LEN_W = TX_LEN_W,
  parameter int unsigned REP_W = TX_REP_W
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [LEN_W-1:0] in_len;
  logic [REP_W-1:0] in_rep;
  logic             out;
  logic             out_valid;
  logic             done;

  modport master (
    output in_valid, in_data, in_len, in_rep,
    input  in_ready, out, out_valid, done
  );

  modport slave (
    input  in_valid, in_data, in_len, in_rep,
    output in_ready, out, out_valid, done
  );

endinterface

// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: shifts an accepted word out MSB-first, one bit per clk,
// optionally repeating it back-to-back, then pulses done for one cycle.
module serial_pattern_tx
  import serial_pattern_tx_pkg::*;
#(
  parameter int unsigned WIDTH = TX_WIDTH,
  parameter int unsigned LEN_W = TX_LEN_W,
  parameter int unsigned REP_W = TX_REP_W
) (
  input  logic                clk,
  input  logic                reset,
  serial_pattern_tx_if.slave  bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] save_q, save_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [REP_W-1:0] rep_left_q, rep_left_d;
  logic             out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic             done_q, done_d;

  logic [LEN_W-1:0] len_eff_c;
  logic [WIDTH-1:0] aligned_c;
  logic             accept_c;

  // Out-of-range lengths fall back to a full word; the word is left-aligned so the MSB is always sent first.
  assign len_eff_c = ((bus.in_len == '0) || (32'(bus.in_len) > WIDTH)) ? LEN_W'(WIDTH) : bus.in_len;
  assign aligned_c = bus.in_data << (LEN_W'(WIDTH) - len_eff_c);
  assign accept_c  = bus.in_valid && (state_q == S_IDLE);

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.done      = done_q;

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    save_d      = save_q;
    len_d       = len_q;
    bit_cnt_d   = bit_cnt_q;
    rep_left_d  = rep_left_q;
    out_d       = 1'b0;
    out_valid_d = 1'b0;
    done_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          state_d    = S_SEND;
          shreg_d    = aligned_c;
          save_d     = aligned_c;
          len_d      = len_eff_c;
          bit_cnt_d  = len_eff_c - LEN_W'(1);
          rep_left_d = bus.in_rep;
        end
      end
      S_SEND: begin
        if (bit_cnt_q != '0) begin
          shreg_d   = shreg_q << 1;
          bit_cnt_d = bit_cnt_q - LEN_W'(1);
        end else if (rep_left_q != '0) begin
          // Reload the saved word with no gap bit so passes abut.
          shreg_d    = save_q;
          bit_cnt_d  = len_q - LEN_W'(1);
          rep_left_d = rep_left_q - REP_W'(1);
        end else begin
          state_d = S_DONE;
          shreg_d = '0;
          done_d  = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Output registers present the bit that the next state will be sending.
    if (state_d == S_SEND) begin
      out_d       = shreg_d[WIDTH-1];
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      shreg_q     <= '0;
      save_q      <= '0;
      len_q       <= '0;
      bit_cnt_q   <= '0;
      rep_left_q  <= '0;
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      save_q      <= save_d;
      len_q       <= len_d;
      bit_cnt_q   <= bit_cnt_d;
      rep_left_q  <= rep_left_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Bench for serial_pattern_tx: table vectors, handshake/reset corner sequences, and random words
// against a queue-based stream model with a 110011 match counter standing in for the detector.
module tb_serial_pattern_tx;
  import serial_pattern_tx_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  serial_pattern_tx_if bus ();

  serial_pattern_tx dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [5:0]  data;
    logic [2:0]  len;
    logic [3:0]  rep;
    logic [31:0] exp_bits;
    int          exp_n;
    int          exp_hits;
  } vec_t;

  vec_t       vecs[7];
  int         checks = 0;
  int         errors = 0;
  bit         exp_q[$];
  int         hits;
  int         seen;
  logic [5:0] hist;

  task automatic chk_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference stream: every pass emits bits L-1..0 of the word, rep+1 passes in a row.
  function automatic void build_exp(input logic [5:0] d, input logic [2:0] l, input logic [3:0] r);
    int eff;
    eff = (l == 3'd0 || int'(l) > 6) ? 6 : int'(l);
    for (int p = 0; p <= int'(r); p++)
      for (int i = eff - 1; i >= 0; i--)
        exp_q.push_back(d[i]);
  endfunction

  // Offer one word in IDLE and check every cycle of its SEND and DONE phases against exp_q.
  task automatic run_word(input logic [5:0] d, input logic [2:0] l, input logic [3:0] r,
                          input bit hold, input bit pulse);
    int n;
    int guard;
    n = exp_q.size();
    hits = 0;
    seen = 0;
    hist = '0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_len   = l;
    bus.in_rep   = r;
    guard = 0;
    while (bus.in_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk_bit("ready_idle", bus.in_ready, 1'b1);
    @(negedge clk);
    if (!hold) bus.in_valid = 1'b0;
    for (int k = 0; k < n; k++) begin
      if (pulse && k == 1) begin
        bus.in_valid = 1'b1;
        bus.in_data  = ~d;
        bus.in_len   = 3'd1;
      end
      if (pulse && k == 2) bus.in_valid = 1'b0;
      chk_bit("out_valid_send", bus.out_valid, 1'b1);
      chk_bit("out_bit", bus.out, exp_q[k]);
      chk_bit("ready_send", bus.in_ready, 1'b0);
      chk_bit("done_send", bus.done, 1'b0);
      hist = {hist[4:0], bus.out};
      seen++;
      if (seen >= 6 && hist == 6'b110011) hits++;
      @(negedge clk);
    end
    chk_bit("done_pulse", bus.done, 1'b1);
    chk_bit("out_valid_done", bus.out_valid, 1'b0);
    chk_bit("out_done", bus.out, 1'b0);
    chk_bit("ready_done", bus.in_ready, 1'b0);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    logic [5:0] rd;
    logic [2:0] rl;
    logic [3:0] rr;

    vecs[0] = '{6'b110011, 3'd6, 4'd0,  32'b110011,       6,  1};
    vecs[1] = '{6'b000101, 3'd3, 4'd0,  32'b101,          3,  0};
    vecs[2] = '{6'b110011, 3'd6, 4'd1,  32'b110011110011, 12, 2};
    vecs[3] = '{6'b100000, 3'd0, 4'd0,  32'b100000,       6,  0};
    vecs[4] = '{6'b111110, 3'd1, 4'd2,  32'b000,          3,  0};
    vecs[5] = '{6'b101010, 3'd7, 4'd0,  32'b101010,       6,  0};
    vecs[6] = '{6'b000001, 3'd1, 4'd15, 32'hFFFF,         16, 0};

    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_len   = '0;
    bus.in_rep   = '0;
    repeat (2) @(negedge clk);
    chk_bit("rst_out", bus.out, 1'b0);
    chk_bit("rst_out_valid", bus.out_valid, 1'b0);
    chk_bit("rst_done", bus.done, 1'b0);
    reset = 1'b0;
    #1;
    chk_bit("rst_ready", bus.in_ready, 1'b1);

    for (int v = 0; v < 7; v++) begin
      for (int k = vecs[v].exp_n - 1; k >= 0; k--) exp_q.push_back(vecs[v].exp_bits[k]);
      run_word(vecs[v].data, vecs[v].len, vecs[v].rep, 1'b0, 1'b0);
      chk_int("detector_hits", hits, vecs[v].exp_hits);
    end

    // in_valid pulsed mid-word must not disturb the word in flight
    build_exp(6'b110011, 3'd6, 4'd0);
    run_word(6'b110011, 3'd6, 4'd0, 1'b0, 1'b1);
    chk_int("pulse_hits", hits, 1);

    // in_valid held through DONE: the second word is accepted only once back in IDLE
    build_exp(6'b101101, 3'd6, 4'd0);
    run_word(6'b101101, 3'd6, 4'd0, 1'b1, 1'b0);
    build_exp(6'b101101, 3'd6, 4'd0);
    run_word(6'b101101, 3'd6, 4'd0, 1'b0, 1'b0);

    // Reset during bit 3 of a word: outputs drop at once, no done, next word intact
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 6'b110011;
    bus.in_len   = 3'd6;
    bus.in_rep   = 4'd0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk_bit("mid_valid_before_rst", bus.out_valid, 1'b1);
    reset = 1'b1;
    #1;
    chk_bit("mid_rst_out_valid", bus.out_valid, 1'b0);
    chk_bit("mid_rst_out", bus.out, 1'b0);
    chk_bit("mid_rst_done", bus.done, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk_bit("mid_rst_ready", bus.in_ready, 1'b1);
    repeat (6) begin
      @(negedge clk);
      chk_bit("post_rst_no_done", bus.done, 1'b0);
      chk_bit("post_rst_idle_valid", bus.out_valid, 1'b0);
    end
    build_exp(6'b110011, 3'd6, 4'd0);
    run_word(6'b110011, 3'd6, 4'd0, 1'b0, 1'b0);
    chk_int("post_rst_hits", hits, 1);

    for (int t = 0; t < 40; t++) begin
      rd = 6'($urandom);
      rl = 3'($urandom_range(0, 7));
      rr = 4'($urandom_range(0, 3));
      build_exp(rd, rl, rr);
      run_word(rd, rl, rr, 1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
